// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg -- shared types and default widths for the div_ctrl block.
//
// Contents:
//   CNT_W_DEF   default width of the divisor and cycle counter
//   TICK_W_DEF  default width of the tick target and tick counter
//   state_t     controller state encoding (IDLE, RUN, DONE)
package div_ctrl_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int TICK_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_ctrl_cnt.sv
// div_ctrl_cnt -- free-running cycle counter with terminal-count decode.
//
// The counter advances while en is high and wraps to zero on the cycle it
// reaches div-1. wrap is a combinational decode of the current count, so the
// terminal cycle is flagged with no added latency.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears the count
//   clr   synchronous clear (takes priority over en)
//   en    count enable
//   div   period in cycles; must be non-zero (caller guarantees >= 1)
//   wrap  high on the cycle the count equals div-1 while en is high
import div_ctrl_pkg::*;

module div_ctrl_cnt #(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] div,
    output logic         wrap
);

    logic [W-1:0] cnt_q;

    // div is never zero, so div-1 cannot underflow.
    assign wrap = en && (cnt_q == div - W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl -- programmable tick generator with one-shot and periodic modes.
//
// A configuration (divisor, tick target, mode) is accepted while IDLE. start
// launches a run: a one-cycle tick is issued every div_q cycles. In one-shot
// mode the run ends after ticks_q ticks with a one-cycle done pulse; in
// periodic mode it runs until stop. stop aborts a run without done.
//
// Optional feature: define DIV_CTRL_IRQ_EN to add a sticky completion
// interrupt (irq, cleared by irq_clr).
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   cfg_valid     configuration offered
//   cfg_ready     configuration accepted (high only in IDLE)
//   cfg_div       cycles per tick (0 treated as 1)
//   cfg_ticks     one-shot tick target (0 treated as 1)
//   cfg_periodic  1 = periodic, 0 = one-shot
//   start, stop   run / abort commands
//   irq_clr, irq  interrupt clear / sticky done flag (DIV_CTRL_IRQ_EN only)
//   tick          one-cycle pulse per divisor period
//   tick_cnt      ticks issued since the last start
//   busy          high while running
//   done          one-cycle completion pulse
import div_ctrl_pkg::*;

module div_ctrl #(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [TICK_W-1:0] cfg_ticks,
    input  logic              cfg_periodic,
    input  logic              start,
    input  logic              stop,
`ifdef DIV_CTRL_IRQ_EN
    input  logic              irq_clr,
    output logic              irq,
`endif
    output logic              tick,
    output logic [TICK_W-1:0] tick_cnt,
    output logic              busy,
    output logic              done
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  div_q;
    logic [TICK_W-1:0] ticks_q;
    logic              periodic_q;
    logic [TICK_W-1:0] tick_cnt_q;

    logic cfg_hs;
    logic launch;
    logic wrap;
    logic terminal;

    assign cfg_hs = cfg_valid && (state == IDLE);
    assign launch = start && (state == IDLE);

    // A one-shot run ends on the tick that brings tick_cnt up to the target.
    assign terminal = wrap && !periodic_q && ((tick_cnt_q + TICK_W'(1)) == ticks_q);

    // ------------------------------------------------------------------
    // Cycle counter. Cleared on the launch edge so RUN cycle 1 sees zero;
    // the first tick therefore lands on RUN cycle div_q.
    // ------------------------------------------------------------------
    div_ctrl_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (state == RUN),
        .div  (div_q),
        .wrap (wrap)
    );

    // ------------------------------------------------------------------
    // Configuration registers. A handshake coinciding with start lands on
    // the same edge that enters RUN, so the new values govern that run.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= CNT_W'(1);
            ticks_q    <= TICK_W'(1);
            periodic_q <= 1'b0;
        end else if (cfg_hs) begin
            div_q      <= (cfg_div == '0)   ? CNT_W'(1)  : cfg_div;
            ticks_q    <= (cfg_ticks == '0) ? TICK_W'(1) : cfg_ticks;
            periodic_q <= cfg_periodic;
        end
    end

    // ------------------------------------------------------------------
    // Tick counter: cleared on launch, wraps naturally in periodic mode,
    // and holds through stop, DONE and IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (launch) begin
            tick_cnt_q <= '0;
        end else if (wrap) begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    assign tick_cnt = tick_cnt_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. stop outranks a simultaneous terminal tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (stop)          state_nxt = IDLE;
                else if (terminal) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. tick is the counter's terminal decode, which is only
    // enabled in RUN, so it cannot fire elsewhere.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = (state == IDLE);
        busy      = (state == RUN);
        done      = (state == DONE);
        tick      = wrap;
    end

`ifdef DIV_CTRL_IRQ_EN
    // Sticky completion flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, meaning the width of the divisor and cycle counter.
REQ-002 The module SHALL have parameter TICK_W, default 8, meaning the width of the tick target and tick counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port cfg_valid, input, 1 bit: configuration offered.
REQ-006 The module SHALL have port cfg_ready, output, 1 bit: configuration accepted this cycle when high with cfg_valid.
REQ-007 The module SHALL have port cfg_div, input, CNT_W bits: divisor, i.e. cycles per tick.
REQ-008 The module SHALL have port cfg_ticks, input, TICK_W bits: tick target for one-shot mode.
REQ-009 The module SHALL have port cfg_periodic, input, 1 bit: 1 selects periodic mode, 0 selects one-shot mode.
REQ-010 The module SHALL have ports start and stop, inputs, 1 bit each: run and abort commands.
REQ-011 The module SHALL have port tick, output, 1 bit: one-cycle pulse at each divisor period.
REQ-012 The module SHALL have port tick_cnt, output, TICK_W bits: ticks issued since the last start.
REQ-013 The module SHALL have ports busy and done, outputs, 1 bit each: busy is high in RUN; done is a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 cfg_ready SHALL equal (state==IDLE).
- A cfg_valid&&cfg_ready handshake SHALL latch div_q, ticks_q and periodic_q.
- A cfg_div of 0 SHALL be stored as 1; a cfg_ticks of 0 SHALL be stored as 1.
REQ-016 start in IDLE SHALL move the FSM to RUN on the next cycle.
- Entering RUN SHALL clear the cycle counter and tick_cnt.
- If a handshake occurs in the same cycle as start, the new configuration SHALL take effect for that run.
REQ-017 In RUN, the cycle counter SHALL increment each cycle.
- When the counter equals div_q-1, tick SHALL be 1 that cycle, the counter SHALL wrap to 0, and tick_cnt SHALL increment.
- The first tick SHALL occur on the div_q-th RUN cycle.
REQ-018 tick SHALL be a decode of state and counter with zero added latency; tick SHALL never be high outside RUN.
REQ-019 In one-shot mode, the tick that makes tick_cnt equal ticks_q SHALL move the FSM to DONE.
- DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 In periodic mode, ticks_q SHALL be ignored, tick_cnt SHALL wrap modulo 2^TICK_W, and the FSM SHALL never enter DONE.
REQ-021 stop in RUN SHALL force IDLE on the next cycle without a done pulse.
- stop SHALL take priority over a simultaneous terminal tick: that tick SHALL still pulse but no DONE follows.
- tick_cnt SHALL hold its value after stop.
REQ-022 start outside IDLE and stop outside RUN SHALL be ignored.
REQ-023 tick_cnt SHALL hold its value in IDLE and DONE until the next start.

Reset
REQ-024 rst SHALL put the FSM in IDLE and clear the counter, tick_cnt, tick, busy and done.
- rst SHALL set div_q=1, ticks_q=1 and periodic_q=0.
- rst SHALL take priority over every other input, including in mid-run.

Configuration
REQ-025 With DIV_CTRL_IRQ_EN defined, the module SHALL add input irq_clr and output irq.
- irq SHALL be a sticky flag set by done and cleared by irq_clr; set SHALL win over clear in the same cycle; rst SHALL clear irq.
- Without the macro, irq_clr and irq SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-026 A package div_ctrl_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default width constants.
REQ-027 The cycle counter and its terminal decode SHALL be a sub-module div_ctrl_cnt.
- div_ctrl_cnt ports: clk, rst, clr, en, div, wrap.

Verification
REQ-028 The bench SHALL cover these scenarios:
- cfg div=4, ticks=3, one-shot, start -> ticks on RUN cycles 4, 8, 12; done one cycle later; tick_cnt=3.
- cfg div=0, periodic, start -> tick every cycle; tick_cnt wraps 255->0 at TICK_W=8.
- div=5, stop on RUN cycle 5 (terminal tick) -> tick pulses; IDLE next cycle; no done; tick_cnt=1.
- cfg_valid held during RUN -> cfg_ready=0 and div_q unchanged; accepted in the first IDLE cycle.
- rst asserted on RUN cycle 3 of a div=8 run -> all outputs 0 and IDLE next cycle.
- DIV_CTRL_IRQ_EN, done coinciding with irq_clr -> irq=1; irq_clr alone the next cycle -> irq=0.
